// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the EX stage.
// States: IDLE = no op in flight | MUL = multiply counting down | DIV = divide counting down
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   opa, opa_n, opb, opb_n;
    logic          uns, uns_n;
    logic [31:0]   hi_n, lo_n;

    logic [63:0] ext_a, ext_b, prod;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, uq, ur, quot, rem;

    // Arithmetic runs on latched operands; signed divide goes through magnitudes
    // so the 0x80000000 / -1 case wraps cleanly instead of overflowing.
    always_comb begin
        ext_a = {{32{~uns & opa[31]}}, opa};
        ext_b = {{32{~uns & opb[31]}}, opb};
        prod  = ext_a * ext_b;
        neg_a = ~uns & opa[31];
        neg_b = ~uns & opb[31];
        mag_a = neg_a ? (32'd0 - opa) : opa;
        mag_b = neg_b ? (32'd0 - opb) : opb;
        div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem   = neg_a ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        opa_n   = opa;
        opb_n   = opb;
        uns_n   = uns;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    case (op)
                        3'd0, 3'd1: begin
                            opa_n   = rs_data;
                            opb_n   = rt_data;
                            uns_n   = op[0];
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = ST_MUL;
                        end
                        3'd2, 3'd3: begin
                            opa_n   = rs_data;
                            opb_n   = rt_data;
                            uns_n   = op[0];
                            cnt_n   = CW'(DIV_CYCLES);
                            state_n = ST_DIV;
                        end
                        3'd4:    hi_n = rs_data;
                        3'd5:    lo_n = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (abort) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (cnt == CW'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (state == ST_MUL) begin
                        hi_n = prod[63:32];
                        lo_n = prod[31:0];
                    end else if (opb != 32'd0) begin
                        hi_n = rem;
                        lo_n = quot;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            uns   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            opa   <= opa_n;
            opb   <= opb_n;
            uns   <= uns_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: scoreboard of expected {hi,lo} checked when busy drops.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, start, abort;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_res[$];
    int          sb_lat[$];
    logic [63:0] pre;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .abort(abort),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue an op, optionally pulse a conflicting start at busy cycle 'inject',
    // then count busy cycles and compare against the scoreboard head.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int n,
                          input int inject);
        int cyc;
        logic [63:0] e;
        int el;
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        sb_res.push_back(exp);
        sb_lat.push_back(n);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            rs_data = $urandom;
            rt_data = $urandom;
            if (cyc == inject) begin
                start = 1'b1; op = 3'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e  = sb_res.pop_front();
        el = sb_lat.pop_front();
        check({tag, "_lat"}, 64'(cyc), 64'(el));
        check({tag, "_hilo"}, {hi, lo}, e);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0;
        rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        check("idle_hold", {31'd0, busy, hi, lo}, 64'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 0);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 0);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 0);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 10, 0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, 0);
        run_op("div_neg_div", 3'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, 0);

        // abort during divide, on busy cycle 4
        pre = {hi, lo};
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, pre);

        // abort on the commit edge
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("commit_edge_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_commit_hilo", {31'd0, busy, hi, lo}, {32'd0, pre[63:32]} << 32 | {32'd0, pre[31:0]});

        // abort together with MTHI in idle
        start = 1'b1; op = 3'd4; rs_data = 32'hDEAD_BEEF; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_mthi", {hi, lo}, pre);

        start = 1'b1; op = 3'd4; rs_data = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi", {31'd0, busy, hi}, 64'h0000_1234);
        start = 1'b1; op = 3'd5; rs_data = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        check("mtlo", {hi, lo}, 64'h0000_1234_CAFE_0001);
        start = 1'b1; op = 3'd7; rs_data = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        check("noop", {31'd0, busy, hi, lo}, 64'h0000_1234_CAFE_0001);

        run_op("start_in_busy", 3'd1, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 5, 2);
        check("after_inject_idle", 64'(busy), 64'd0);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_data = 32'd50; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("reset_mid", {31'd0, busy, hi | lo}, 64'd0);
        @(negedge clk);
        check("reset_mid_hold", {31'd0, busy, hi, lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
